exe_stage_mdv: RTL and testbench

// - Execute stage of the 5-stage in-order pipeline (IF/ID/EXE/MEM/WB), between decode (ds) and memory (ms) stages.
// - Computes ALU results, issues data-SRAM requests with byte write strobes and sub-word alignment, flags misaligned accesses.
// - Optional iterative divider; stalls the stage via es_ready_go while it runs.

---
 rtl/exe_stage_mdv.sv | 200 ++++++++++++++++++++
 tb/tb_exe_stage_mdv.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mdv.sv
// Execute stage: ALU, data-SRAM request generation with sub-word alignment, misalignment flag.
// Optional restoring divider, enabled by defining EXE_DIV_EN.
module exe_stage_mdv #(
   parameter int XLEN = 32,
   parameter int PCW  = 32
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      ms_allowin,
   output logic                                      es_allowin,
   input  logic                                      ds_to_es_valid,
   input  logic [15+3*XLEN+PCW-1:0]                  ds_to_es_bus,
   output logic                                      es_to_ms_valid,
   output logic [12+$clog2(XLEN/8)+XLEN+PCW-1:0]     es_to_ms_bus,
   output logic                                      data_sram_en,
   output logic [XLEN/8-1:0]                         data_sram_we,
   output logic [XLEN-1:0]                           data_sram_addr,
   output logic [XLEN-1:0]                           data_sram_wdata
);
   localparam int LANES = XLEN / 8;
   localparam int LB    = $clog2(LANES);
   localparam int SHW   = $clog2(XLEN);
   localparam int DS_W  = 15 + 3 * XLEN + PCW;

   logic            es_valid_q;
   logic [DS_W-1:0] ds_bus_q;
   logic            es_ready_go;

   logic [3:0]      alu_op;
   logic [1:0]      mem_size;
   logic            mem_sext, mem_en, mem_we, gr_we;
   logic [4:0]      dest;
   logic [XLEN-1:0] src1, src2, rkd;
   logic [PCW-1:0]  pc;

   assign {alu_op, mem_size, mem_sext, mem_en, mem_we, gr_we, dest, src1, src2, rkd, pc} = ds_bus_q;

   assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid_q && es_ready_go;

   always_ff @(posedge clk) begin
      if (reset) begin
         es_valid_q <= 1'b0;
      end else if (es_allowin) begin
         es_valid_q <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allowin) begin
         ds_bus_q <= ds_to_es_bus;
      end
   end

   logic [XLEN-1:0] alu_res, div_res, mem_addr;
   logic [SHW-1:0]  shamt;
   assign shamt = src2[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         4'd0:    alu_res = src1 + src2;
         4'd1:    alu_res = src1 - src2;
         4'd2:    alu_res = src1 & src2;
         4'd3:    alu_res = src1 | src2;
         4'd4:    alu_res = src1 ^ src2;
         4'd5:    alu_res = src1 << shamt;
         4'd6:    alu_res = src1 >> shamt;
         4'd7:    alu_res = $signed(src1) >>> shamt;
         4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
         4'd9:    alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
         4'd10, 4'd11, 4'd12, 4'd13: alu_res = div_res;
         default: alu_res = '0;
      endcase
   end

   // Doubleword accesses only exist on a 64-bit datapath; narrower builds fold them to word.
   logic [1:0]    eff_size;
   logic [LB-1:0] addr_lo, lane_mask;
   logic [LANES-1:0] size_mask;
   logic          misalign, ale;

   assign mem_addr = src1 + src2;
   assign eff_size = (XLEN == 32 && mem_size == 2'd3) ? 2'd2 : mem_size;
   assign addr_lo  = mem_addr[LB-1:0];

   always_comb begin
      misalign  = 1'b0;
      size_mask = LANES'(1);
      lane_mask = '0;
      case (eff_size)
         2'd0: begin misalign = 1'b0;             size_mask = LANES'(1);  lane_mask = '0;      end
         2'd1: begin misalign = mem_addr[0];      size_mask = LANES'(3);  lane_mask = LB'(1);  end
         2'd2: begin misalign = |mem_addr[1:0];   size_mask = LANES'(15); lane_mask = LB'(3);  end
         default: begin misalign = |mem_addr[2:0]; size_mask = '1;       lane_mask = '1;      end
      endcase
   end

   assign ale            = mem_en && misalign;
   assign data_sram_en   = es_valid_q && mem_en && !ale && es_ready_go && ms_allowin;
   assign data_sram_we   = (data_sram_en && mem_we) ? (size_mask << addr_lo) : '0;
   assign data_sram_addr = mem_addr;

   // Each lane picks the store-data byte at its offset modulo the access size.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_wlane
      assign data_sram_wdata[8*gi +: 8] = rkd[8*(LB'(gi) & lane_mask) +: 8];
   end

   assign es_to_ms_bus = {ale, mem_en, mem_we, eff_size, mem_sext, addr_lo, gr_we, dest, alu_res, pc};

`ifdef EXE_DIV_EN
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

   div_state_t      state_q, state_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [XLEN:0]   trial;
   logic            is_div, div_signed, src1_neg, src2_neg;
   logic [XLEN-1:0] abs1, abs2;

   assign is_div     = alu_op inside {[4'd10:4'd13]};
   assign div_signed = (alu_op == 4'd10) || (alu_op == 4'd12);
   assign src1_neg   = div_signed && src1[XLEN-1];
   assign src2_neg   = div_signed && src2[XLEN-1];
   assign abs1       = src1_neg ? -src1 : src1;
   assign abs2       = src2_neg ? -src2 : src2;
   assign trial      = {rem_q, quo_q[XLEN-1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      es_ready_go = 1'b1;
      case (state_q)
         DIV_IDLE: begin
            if (es_valid_q && is_div) begin
               es_ready_go = 1'b0;
               state_d     = DIV_BUSY;
               cnt_d       = SHW'(XLEN - 1);
               rem_d       = '0;
               quo_d       = abs1;
               dvs_d       = abs2;
            end
         end
         DIV_BUSY: begin
            es_ready_go = 1'b0;
            if (trial >= {1'b0, dvs_q}) begin
               rem_d = trial[XLEN-1:0] - dvs_q;
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = DIV_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DIV_DONE: begin
            if (ms_allowin) begin
               state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   // Zero divisor is special-cased so a signed dividend does not flip the all-ones quotient.
   always_comb begin
      div_res = '0;
      if (src2 == '0) begin
         div_res = (alu_op == 4'd10 || alu_op == 4'd11) ? '1 : src1;
      end else if (alu_op == 4'd10 || alu_op == 4'd11) begin
         div_res = (src1_neg ^ src2_neg) ? -quo_q : quo_q;
      end else begin
         div_res = src1_neg ? -rem_q : rem_q;
      end
   end
`else
   assign es_ready_go = 1'b1;
   assign div_res     = '0;
`endif

endmodule

// File: tb/tb_exe_stage_mdv.sv
// Self-checking bench for exe_stage_mdv: vector table, random ops against a reference model, handshake corners.
module tb_exe_stage_mdv;
   localparam int XLEN = 32;
   localparam int PCW  = 32;
   localparam int DS_W = 15 + 3 * XLEN + PCW;
   localparam int MS_W = 12 + 2 + XLEN + PCW;
`ifdef EXE_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            ms_allowin;
   logic            es_allowin;
   logic            ds_to_es_valid;
   logic [DS_W-1:0] ds_to_es_bus;
   logic            es_to_ms_valid;
   logic [MS_W-1:0] es_to_ms_bus;
   logic            data_sram_en;
   logic [3:0]      data_sram_we;
   logic [31:0]     data_sram_addr;
   logic [31:0]     data_sram_wdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   exe_stage_mdv #(.XLEN(XLEN), .PCW(PCW)) dut (
      .clk             (clk),
      .reset           (reset),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   typedef struct {
      logic [3:0]  op;
      logic [1:0]  size;
      logic        men;
      logic        mwe;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] rkd;
      logic [31:0] exp_res;
      logic        exp_ale;
      logic        exp_en;
      logic [3:0]  exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << b[4:0];
         4'd6:  return a >> b[4:0];
         4'd7:  return 32'(sa >>> b[4:0]);
         4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         4'd10: begin
            if (!DIV_EN) return 32'd0;
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         4'd11: begin
            if (!DIV_EN) return 32'd0;
            return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         end
         4'd12: begin
            if (!DIV_EN) return 32'd0;
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         4'd13: begin
            if (!DIV_EN) return 32'd0;
            return (b == 32'd0) ? a : a % b;
         end
         default: return 32'd0;
      endcase
   endfunction

   // Issue one instruction into an empty stage with ms always ready, then check the handoff.
   task automatic do_instr(input string tag, input logic [3:0] op, input logic [1:0] size,
                           input logic men, input logic mwe, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] rkd, input logic [31:0] exp_res, input logic exp_ale,
                           input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                           input logic [4:0] dest, input logic [31:0] pc);
      int              lat;
      int              en_cnt;
      int              exp_lat;
      bit              found;
      logic [MS_W-1:0] b;
      logic            en_h;
      logic [3:0]      we_h;
      logic [31:0]     addr_h, wd_h, addr_m;
      exp_lat = (DIV_EN && op >= 4'd10 && op <= 4'd13) ? XLEN + 2 : 1;
      addr_m  = s1 + s2;
      @(negedge clk);
      chk({tag, "_allowin_empty"}, es_allowin, 1);
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = {op, size, 1'b0, men, mwe, !mwe, dest, s1, s2, rkd, pc};
      lat = 0; en_cnt = 0; found = 1'b0;
      b = '0; en_h = 1'b0; we_h = '0; addr_h = '0; wd_h = '0;
      while (!found && lat < 100) begin
         @(negedge clk);
         ds_to_es_valid = 1'b0;
         lat++;
         #1;
         if (data_sram_en) en_cnt++;
         if (es_to_ms_valid) begin
            found = 1'b1;
            b = es_to_ms_bus; en_h = data_sram_en; we_h = data_sram_we;
            addr_h = data_sram_addr; wd_h = data_sram_wdata;
         end
      end
      if (!found) begin
         chk({tag, "_timeout"}, 0, 1);
      end else begin
         chk({tag, "_latency"}, lat, exp_lat);
         chk({tag, "_result"}, b[63:32], exp_res);
         chk({tag, "_ale"}, b[77], exp_ale);
         chk({tag, "_mem_en"}, b[76], men);
         chk({tag, "_mem_size"}, b[74:73], size);
         chk({tag, "_addr_lo"}, b[71:70], addr_m[1:0]);
         chk({tag, "_dest"}, b[68:64], dest);
         chk({tag, "_pc"}, b[31:0], pc);
         chk({tag, "_req_count"}, en_cnt, exp_en ? 1 : 0);
         chk({tag, "_sram_en"}, en_h, exp_en);
         chk({tag, "_sram_we"}, we_h, exp_we);
         if (exp_en) begin
            chk({tag, "_sram_addr"}, addr_h, addr_m);
            chk({tag, "_sram_wdata"}, wd_h, exp_wdata);
         end
         $display("txn %s op=%0d src1=%h src2=%h result=%h lat=%0d", tag, op, s1, s2, b[63:32], lat);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not reach the end, expected completion");
      $fatal(1);
   end

   vec_t        vecs[19];
   int          lat, vcnt;
   bit          found;
   logic [3:0]  r_op, r_we;
   logic [1:0]  r_size;
   logic        r_men, r_mwe, r_ale, r_en;
   logic [31:0] r_s1, r_s2, r_rkd, r_addr, r_wd;
   int          nb;

   initial begin
      vecs[0]  = '{4'd0,  2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,        32'h0,         1'b0, 1'b0, 4'h0, 32'h0};
      vecs[1]  = '{4'd0,  2'd0, 1'b1, 1'b1, 32'h1000,      32'h3,         32'hAB,       32'h1003,      1'b0, 1'b1, 4'h8, 32'hABAB_ABAB};
      vecs[2]  = '{4'd0,  2'd2, 1'b1, 1'b1, 32'h1000,      32'h2,         32'h1234_5678, 32'h1002,     1'b1, 1'b0, 4'h0, 32'h0};
      vecs[3]  = '{4'd0,  2'd1, 1'b1, 1'b1, 32'h1000,      32'h2,         32'h1234,     32'h1002,      1'b0, 1'b1, 4'hC, 32'h1234_1234};
      vecs[4]  = '{4'd0,  2'd2, 1'b1, 1'b0, 32'h2000,      32'h4,         32'h0,        32'h2004,      1'b0, 1'b1, 4'h0, 32'h0};
      vecs[5]  = '{4'd1,  2'd0, 1'b0, 1'b0, 32'h5,         32'h7,         32'h0,        32'hFFFF_FFFE, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[6]  = '{4'd7,  2'd0, 1'b0, 1'b0, 32'h8000_0000, 32'h24,        32'h0,        32'hF800_0000, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[7]  = '{4'd8,  2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,        32'h1,         1'b0, 1'b0, 4'h0, 32'h0};
      vecs[8]  = '{4'd9,  2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,        32'h0,         1'b0, 1'b0, 4'h0, 32'h0};
      vecs[9]  = '{4'd5,  2'd0, 1'b0, 1'b0, 32'h1,         32'd31,        32'h0,        32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[10] = '{4'd14, 2'd0, 1'b0, 1'b0, 32'h123,       32'h456,       32'h0,        32'h0,         1'b0, 1'b0, 4'h0, 32'h0};
      vecs[11] = '{4'd10, 2'd0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'h2,         32'h0,        DIV_EN ? 32'hFFFF_FFFD : 32'h0, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[12] = '{4'd12, 2'd0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'h2,         32'h0,        DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[13] = '{4'd11, 2'd0, 1'b0, 1'b0, 32'h5,         32'h0,         32'h0,        DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[14] = '{4'd10, 2'd0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        DIV_EN ? 32'h8000_0000 : 32'h0, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[15] = '{4'd13, 2'd0, 1'b0, 1'b0, 32'h5,         32'h0,         32'h0,        DIV_EN ? 32'h5 : 32'h0,         1'b0, 1'b0, 4'h0, 32'h0};
      vecs[16] = '{4'd0,  2'd1, 1'b1, 1'b0, 32'h1000,      32'h1,         32'h0,        32'h1001,      1'b1, 1'b0, 4'h0, 32'h0};
      vecs[17] = '{4'd4,  2'd0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,        32'h0FF0_0FF0, 1'b0, 1'b0, 4'h0, 32'h0};
      vecs[18] = '{4'd6,  2'd0, 1'b0, 1'b0, 32'h8000_0000, 32'd31,        32'h0,        32'h1,         1'b0, 1'b0, 4'h0, 32'h0};

      reset = 1'b1; ms_allowin = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_valid", es_to_ms_valid, 0);
      chk("reset_sram_en", data_sram_en, 0);
      chk("reset_sram_we", data_sram_we, 0);
      chk("reset_allowin", es_allowin, 1);

      for (int i = 0; i < 19; i++) begin
         do_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].size, vecs[i].men, vecs[i].mwe,
                  vecs[i].s1, vecs[i].s2, vecs[i].rkd, vecs[i].exp_res, vecs[i].exp_ale,
                  vecs[i].exp_en, vecs[i].exp_we, vecs[i].exp_wdata, 5'(i), 32'h100 + 32'(4 * i));
      end

      // Store halfword held by a stalled ms: no request until the handoff cycle.
      @(negedge clk);
      ms_allowin = 1'b0; ds_to_es_valid = 1'b1;
      ds_to_es_bus = {4'd0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h3000, 32'h0, 32'h0000_BEEF, 32'h400};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ds_to_es_valid = 1'b0;
         #1;
         chk("stall_valid", es_to_ms_valid, 1);
         chk("stall_allowin", es_allowin, 0);
         chk("stall_no_req", data_sram_en, 0);
         chk("stall_result", es_to_ms_bus[63:32], 32'h3000);
      end
      @(negedge clk);
      ms_allowin = 1'b1;
      #1;
      chk("stall_release_en", data_sram_en, 1);
      chk("stall_release_we", data_sram_we, 4'b0011);
      chk("stall_release_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      chk("stall_release_allowin", es_allowin, 1);
      @(negedge clk);
      #1;
      chk("stall_after_valid", es_to_ms_valid, 0);
      chk("stall_after_en", data_sram_en, 0);

`ifdef EXE_DIV_EN
      // Divide completes while ms is stalled: DONE must hold the result.
      @(negedge clk);
      ms_allowin = 1'b0; ds_to_es_valid = 1'b1;
      ds_to_es_bus = {4'd10, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h500};
      lat = 0; found = 1'b0;
      while (!found && lat < 100) begin
         @(negedge clk);
         ds_to_es_valid = 1'b0;
         lat++;
         #1;
         if (es_to_ms_valid) found = 1'b1;
      end
      chk("divstall_latency", lat, XLEN + 2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("divstall_valid", es_to_ms_valid, 1);
         chk("divstall_result", es_to_ms_bus[63:32], 32'h8000_0000);
         chk("divstall_allowin", es_allowin, 0);
      end
      @(negedge clk);
      ms_allowin = 1'b1;
      #1;
      chk("divstall_handoff_allowin", es_allowin, 1);
      @(negedge clk);
      #1;
      chk("divstall_after_valid", es_to_ms_valid, 0);
`endif

      // Reset while an instruction is pending (mid-divide when the divider is built in).
      @(negedge clk);
      ms_allowin = 1'b0; ds_to_es_valid = 1'b1;
      ds_to_es_bus = {4'd11, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd100, 32'd7, 32'h0, 32'h600};
      repeat (10) begin
         @(negedge clk);
         ds_to_es_valid = 1'b0;
      end
      #1;
      chk("abort_pending_allowin", es_allowin, 0);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("abort_valid", es_to_ms_valid, 0);
      chk("abort_allowin", es_allowin, 1);
      reset = 1'b0;
      ms_allowin = 1'b1;
      do_instr("after_abort_add", 4'd0, 2'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'h0, 32'd5, 1'b0, 1'b0, 4'h0, 32'h0, 5'd1, 32'h700);
      vcnt = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (es_to_ms_valid) vcnt++;
      end
      chk("abort_no_late_output", vcnt, 0);

      for (int i = 0; i < 300; i++) begin
         r_op   = 4'($urandom_range(0, 15));
         r_size = 2'($urandom_range(0, 2));
         r_men  = 1'($urandom_range(0, 1));
         r_mwe  = r_men & 1'($urandom_range(0, 1));
         r_s1   = $urandom;
         r_s2   = $urandom;
         r_rkd  = $urandom;
         case ($urandom_range(0, 5))
            0: r_s2 = 32'h0;
            1: r_s2 = 32'hFFFF_FFFF;
            2: r_s2 = 32'($urandom_range(0, 7));
            default: ;
         endcase
         if ($urandom_range(0, 7) == 0) r_s1 = 32'h8000_0000;
         r_addr = r_s1 + r_s2;
         nb     = 1 << r_size;
         r_ale  = r_men && ((r_addr % nb) != 0);
         r_en   = r_men && !r_ale;
         r_we   = (r_en && r_mwe) ? 4'(((1 << nb) - 1) << (r_addr % 4)) : 4'h0;
         for (int k = 0; k < 4; k++) r_wd[8*k +: 8] = r_rkd[8*(k % nb) +: 8];
         do_instr($sformatf("rnd%0d", i), r_op, r_size, r_men, r_mwe, r_s1, r_s2, r_rkd,
                  model_res(r_op, r_s1, r_s2), r_ale, r_en, r_we, r_wd, 5'($urandom_range(0, 31)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
